// File: rtl/fpu_issue_ctrl_if.sv
// Decode-side request, FPU launch, writeback and hazard-query signals of the FP issue controller.
// The master modport is the decode stage; the slave modport is the controller itself.
interface fpu_issue_ctrl_if;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [4:0]  req_fs;
  logic [4:0]  req_ft;
  logic [4:0]  req_fd;
  logic        flush;
  logic [4:0]  chk_addr;
  logic        req_ready;
  logic        stall;
  logic        fpu_start;
  logic [1:0]  fpu_op;
  logic [4:0]  fpu_fs;
  logic [4:0]  fpu_ft;
  logic [4:0]  fpu_fd;
  logic        wb_valid;
  logic [4:0]  wb_fd;
  logic        chk_hazard;
  logic        busy;
  logic [15:0] stall_cnt;

  modport master (
    output req_valid, req_op, req_fs, req_ft, req_fd, flush, chk_addr,
    input  req_ready, stall, fpu_start, fpu_op, fpu_fs, fpu_ft, fpu_fd,
           wb_valid, wb_fd, chk_hazard, busy, stall_cnt
  );

  modport slave (
    input  req_valid, req_op, req_fs, req_ft, req_fd, flush, chk_addr,
    output req_ready, stall, fpu_start, fpu_op, fpu_fs, fpu_ft, fpu_fd,
           wb_valid, wb_fd, chk_hazard, busy, stall_cnt
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Issue controller for the non-pipelined FPU: accepts one FP op at a time, times its
// latency with a down-counter, strobes writeback and answers RAW queries on the in-flight fd.
module fpu_issue_ctrl #(
  parameter int LAT_ADD = 3,
  parameter int LAT_MUL = 5,
  parameter int LAT_DIV = 12
) (
  input  logic              clk,
  input  logic              rst,
  fpu_issue_ctrl_if.slave   bus
);

  localparam int LAT_MAX = (LAT_ADD > LAT_MUL) ? ((LAT_ADD > LAT_DIV) ? LAT_ADD : LAT_DIV)
                                               : ((LAT_MUL > LAT_DIV) ? LAT_MUL : LAT_DIV);
  localparam int CW = $clog2(LAT_MAX) + 1;

  typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           start_q;
  logic [1:0]     op_q;
  logic [4:0]     fs_q, ft_q, fd_q;
  logic [15:0]    stall_cnt_q;
  logic           ready;
  logic           accept;

  function automatic logic [CW-1:0] lat_of(input logic [1:0] op);
    case (op)
      2'b10:   lat_of = CW'(LAT_MUL - 1);
      2'b11:   lat_of = CW'(LAT_DIV - 1);
      default: lat_of = CW'(LAT_ADD - 1);
    endcase
  endfunction

  // In WB a new op may only issue if it does not read the result being written this cycle.
  always_comb begin
    ready = 1'b0;
    case (state_q)
      IDLE:    ready = ~bus.flush;
      WB:      ready = ~bus.flush & (bus.req_fs != fd_q) & (bus.req_ft != fd_q);
      default: ready = 1'b0;
    endcase
    if (rst) ready = 1'b0;
  end

  assign accept = bus.req_valid & ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          cnt_d   = lat_of(bus.req_op);
        end
      end
      RUN: begin
        if (bus.flush)          state_d = IDLE;
        else if (cnt_q != '0)   cnt_d   = cnt_q - 1'b1;
        else                    state_d = WB;
      end
      WB: begin
        if (accept) begin
          state_d = RUN;
          cnt_d   = lat_of(bus.req_op);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= accept;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= '0;
      fs_q <= '0;
      ft_q <= '0;
      fd_q <= '0;
    end else if (accept) begin
      op_q <= bus.req_op;
      fs_q <= bus.req_fs;
      ft_q <= bus.req_ft;
      fd_q <= bus.req_fd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         stall_cnt_q <= '0;
    else if (bus.stall && stall_cnt_q != 16'hFFFF)   stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign bus.req_ready  = ready;
  assign bus.stall      = bus.req_valid & ~ready;
  assign bus.fpu_start  = start_q;
  assign bus.fpu_op     = op_q;
  assign bus.fpu_fs     = fs_q;
  assign bus.fpu_ft     = ft_q;
  assign bus.fpu_fd     = fd_q;
  assign bus.wb_valid   = (state_q == WB);
  assign bus.wb_fd      = fd_q;
  assign bus.chk_hazard = (state_q != IDLE) & (bus.chk_addr == fd_q);
  assign bus.busy       = (state_q != IDLE);
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with default latencies (add 3, mul 5, div 12).
// Cycle n is the interval just before edge n; inputs change and outputs are checked 1-2 ns after each edge.
module tb_fpu_issue_ctrl;

  logic clk;
  logic rst;
  int   checkCnt;
  int   passCnt;

  fpu_issue_ctrl_if bus ();

  fpu_issue_ctrl #(.LAT_ADD(3), .LAT_MUL(5), .LAT_DIV(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic valid, input logic [1:0] op, input logic [4:0] fs,
                               input logic [4:0] ft, input logic [4:0] fd, input logic fl,
                               input logic [4:0] chk);
    bus.req_valid = valid;
    bus.req_op    = op;
    bus.req_fs    = fs;
    bus.req_ft    = ft;
    bus.req_fd    = fd;
    bus.flush     = fl;
    bus.chk_addr  = chk;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCnt++;
    assert (observed === expected) passCnt++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic stepCycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checkCnt = 0;
    passCnt  = 0;
    rst      = 1'b1;
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0);
    stepCycle(2);

    // Reset state
    checkOutput("rst_busy",      32'(bus.busy), 0);
    checkOutput("rst_wb_valid",  32'(bus.wb_valid), 0);
    checkOutput("rst_fpu_start", 32'(bus.fpu_start), 0);
    checkOutput("rst_req_ready", 32'(bus.req_ready), 0);
    checkOutput("rst_stall_cnt", 32'(bus.stall_cnt), 0);
    checkOutput("rst_fpu_fd",    32'(bus.fpu_fd), 0);
    rst = 1'b0;

    // Single add, accepted on the first edge after reset
    applyStimulus(1, 2'b00, 1, 2, 3, 0, 0);
    checkOutput("add_ready_c0", 32'(bus.req_ready), 1);
    checkOutput("add_stall_c0", 32'(bus.stall), 0);
    stepCycle(1);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0);
    checkOutput("add_start_c1", 32'(bus.fpu_start), 1);
    checkOutput("add_busy_c1",  32'(bus.busy), 1);
    checkOutput("add_fd_c1",    32'(bus.fpu_fd), 3);
    checkOutput("add_fs_c1",    32'(bus.fpu_fs), 1);
    checkOutput("add_ft_c1",    32'(bus.fpu_ft), 2);
    checkOutput("add_ready_run", 32'(bus.req_ready), 0);
    stepCycle(1);
    checkOutput("add_start_c2", 32'(bus.fpu_start), 0);
    checkOutput("add_wb_c2",    32'(bus.wb_valid), 0);
    stepCycle(1);
    checkOutput("add_wb_c3",    32'(bus.wb_valid), 0);
    stepCycle(1);
    checkOutput("add_wb_c4",    32'(bus.wb_valid), 1);
    checkOutput("add_wbfd_c4",  32'(bus.wb_fd), 3);
    checkOutput("add_busy_c4",  32'(bus.busy), 1);
    stepCycle(1);
    checkOutput("add_busy_c5",  32'(bus.busy), 0);
    checkOutput("add_wb_c5",    32'(bus.wb_valid), 0);
    checkOutput("add_hold_fd",  32'(bus.fpu_fd), 3);

    // Back-to-back: mul fd=5, then independent add held valid during the mul
    applyStimulus(1, 2'b10, 10, 11, 5, 0, 0);
    stepCycle(1);
    applyStimulus(1, 2'b00, 6, 7, 8, 0, 0);
    checkOutput("b2b_op_mul", 32'(bus.fpu_op), 2);
    checkOutput("b2b_stall_c1", 32'(bus.stall), 1);
    stepCycle(5);
    checkOutput("b2b_wb_c6",    32'(bus.wb_valid), 1);
    checkOutput("b2b_wbfd_c6",  32'(bus.wb_fd), 5);
    checkOutput("b2b_ready_c6", 32'(bus.req_ready), 1);
    checkOutput("b2b_stallcnt", 32'(bus.stall_cnt), 5);
    stepCycle(1);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0);
    checkOutput("b2b_start_c7", 32'(bus.fpu_start), 1);
    checkOutput("b2b_fd_c7",    32'(bus.fpu_fd), 8);
    checkOutput("b2b_wb_c7",    32'(bus.wb_valid), 0);
    stepCycle(2);
    checkOutput("b2b_wb_c9",    32'(bus.wb_valid), 0);
    stepCycle(1);
    checkOutput("b2b_wb_c10",   32'(bus.wb_valid), 1);
    checkOutput("b2b_wbfd_c10", 32'(bus.wb_fd), 8);
    stepCycle(1);

    // Dependent: div fd=4, then add reading f4 must wait for IDLE
    applyStimulus(1, 2'b11, 1, 1, 4, 0, 0);
    stepCycle(1);
    applyStimulus(1, 2'b00, 4, 1, 2, 0, 0);
    stepCycle(12);
    checkOutput("dep_wb_c13",    32'(bus.wb_valid), 1);
    checkOutput("dep_ready_c13", 32'(bus.req_ready), 0);
    checkOutput("dep_stall_c13", 32'(bus.stall), 1);
    stepCycle(1);
    checkOutput("dep_busy_c14",  32'(bus.busy), 0);
    checkOutput("dep_ready_c14", 32'(bus.req_ready), 1);
    checkOutput("dep_stallcnt",  32'(bus.stall_cnt), 18);
    stepCycle(1);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0);
    checkOutput("dep_start_c15", 32'(bus.fpu_start), 1);
    stepCycle(2);
    checkOutput("dep_wb_c17",    32'(bus.wb_valid), 0);
    stepCycle(1);
    checkOutput("dep_wb_c18",    32'(bus.wb_valid), 1);
    checkOutput("dep_wbfd_c18",  32'(bus.wb_fd), 2);
    stepCycle(1);

    // Flush during RUN kills the mul without writeback
    applyStimulus(1, 2'b10, 1, 2, 12, 0, 12);
    stepCycle(1);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 12);
    stepCycle(2);
    applyStimulus(0, 2'b00, 0, 0, 0, 1, 12);
    checkOutput("fl_haz_c3", 32'(bus.chk_hazard), 1);
    stepCycle(1);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 12);
    checkOutput("fl_busy_c4", 32'(bus.busy), 0);
    checkOutput("fl_haz_c4",  32'(bus.chk_hazard), 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("fl_nowb_%0d", i), 32'(bus.wb_valid), 0);
      stepCycle(1);
    end

    // Flush during WB: result still committed, no new accept
    applyStimulus(1, 2'b00, 1, 2, 13, 0, 0);
    stepCycle(1);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0);
    stepCycle(3);
    applyStimulus(1, 2'b00, 20, 21, 22, 1, 0);
    checkOutput("flwb_wb",    32'(bus.wb_valid), 1);
    checkOutput("flwb_ready", 32'(bus.req_ready), 0);
    stepCycle(1);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0);
    checkOutput("flwb_busy",  32'(bus.busy), 0);
    checkOutput("flwb_fd",    32'(bus.fpu_fd), 13);

    // chk_hazard against div fd=9
    applyStimulus(1, 2'b11, 1, 2, 9, 0, 9);
    checkOutput("haz_idle_pre", 32'(bus.chk_hazard), 0);
    stepCycle(1);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 9);
    checkOutput("haz_run_9", 32'(bus.chk_hazard), 1);
    stepCycle(1);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 8);
    checkOutput("haz_run_8", 32'(bus.chk_hazard), 0);
    stepCycle(11);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 9);
    checkOutput("haz_wb_state", 32'(bus.wb_valid), 1);
    checkOutput("haz_wb_9",     32'(bus.chk_hazard), 1);
    stepCycle(1);
    checkOutput("haz_idle_9",   32'(bus.chk_hazard), 0);

    // Async reset in the middle of a div
    applyStimulus(1, 2'b11, 1, 2, 7, 0, 7);
    stepCycle(1);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 7);
    stepCycle(5);
    checkOutput("ar_busy_pre", 32'(bus.busy), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("ar_busy",     32'(bus.busy), 0);
    checkOutput("ar_fd",       32'(bus.fpu_fd), 0);
    checkOutput("ar_haz",      32'(bus.chk_hazard), 0);
    checkOutput("ar_stallcnt", 32'(bus.stall_cnt), 0);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      stepCycle(1);
      checkOutput($sformatf("ar_nowb_%0d", i), 32'(bus.wb_valid | bus.busy), 0);
    end

    // Stall held through flush in IDLE until the counter saturates
    applyStimulus(1, 2'b00, 1, 2, 3, 1, 0);
    checkOutput("sat_ready", 32'(bus.req_ready), 0);
    checkOutput("sat_stall", 32'(bus.stall), 1);
    stepCycle(65534);
    checkOutput("sat_fffe", 32'(bus.stall_cnt), 32'h0000FFFE);
    stepCycle(1);
    checkOutput("sat_ffff", 32'(bus.stall_cnt), 32'h0000FFFF);
    stepCycle(5);
    checkOutput("sat_hold", 32'(bus.stall_cnt), 32'h0000FFFF);
    checkOutput("sat_busy", 32'(bus.busy), 0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
